// File: rtl/ff_bank_pkg.sv
// Shared opcodes, controller state encoding and cell mode select for the
// flip-flop bank sequencer.
package ff_bank_pkg;

  localparam logic [2:0] OP_NOP    = 3'd0;
  localparam logic [2:0] OP_LOAD   = 3'd1;
  localparam logic [2:0] OP_TOGGLE = 3'd2;
  localparam logic [2:0] OP_JK     = 3'd3;
  localparam logic [2:0] OP_RUN    = 3'd4;
  localparam logic [2:0] OP_CLEAR  = 3'd5;
  localparam logic [2:0] OP_PRESET = 3'd6;
  localparam logic [2:0] OP_RSVD   = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RUN  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    MODE_HOLD = 2'd0,
    MODE_D    = 2'd1,
    MODE_T    = 2'd2,
    MODE_JK   = 2'd3
  } cell_mode_e;

endpackage

// File: rtl/ff_bank_if.sv
// Command handshake and bank status bundle between the host and ff_bank_ctrl.
interface ff_bank_if #(
  parameter int WIDTH = 4
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [WIDTH-1:0] cmd_arg;
  logic [WIDTH-1:0] cmd_arg2;
  logic             cmd_abort;
  logic [WIDTH-1:0] q;
  logic             busy;
  logic             done;
  logic             wrap;

  modport master (
    output cmd_valid, cmd_op, cmd_arg, cmd_arg2, cmd_abort,
    input  cmd_ready, q, busy, done, wrap
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_arg, cmd_arg2, cmd_abort,
    output cmd_ready, q, busy, done, wrap
  );
endinterface

// File: rtl/ff_cell.sv
// One bank cell: a flip-flop whose next-state function is selected as D, T,
// JK or hold; preset forces it to its INIT bit.
module ff_cell
  import ff_bank_pkg::*;
#(
  parameter logic INIT_BIT = 1'b1
) (
  input  logic       clock,
  input  logic       preset,
  input  cell_mode_e mode,
  input  logic       d,
  input  logic       t,
  input  logic       j,
  input  logic       k,
  output logic       q
);

  // NOTE: state uses non-blocking assignments and the asynchronous preset
  // sits in the sensitivity list, so it acts without waiting for a clock.
  always_ff @(posedge clock or negedge preset) begin
    if (!preset) begin
      q <= INIT_BIT;
    end else begin
      unique case (mode)
        MODE_D:  q <= d;
        MODE_T:  q <= q ^ t;
        MODE_JK: q <= (j & ~q) | (~k & q);
        default: q <= q;
      endcase
    end
  end

endmodule

// File: rtl/ff_bank_ctrl.sv
// Command sequencer for a bank of WIDTH D/T/JK cells: single-cycle ops go
// through EXEC, RUN counts the bank up for a programmed number of steps.
module ff_bank_ctrl
  import ff_bank_pkg::*;
#(
  parameter int               WIDTH = 4,
  parameter logic [WIDTH-1:0] INIT  = '1
) (
  input  logic     clock,
  input  logic     preset,
  ff_bank_if.slave bus
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  state_e           state;
  logic [2:0]       op_r;
  logic [WIDTH-1:0] arg_r;
  logic [WIDTH-1:0] arg2_r;
  logic [WIDTH-1:0] remaining;
  logic             cmd_ready_r;
  logic             busy_r;
  logic             done_r;
  logic             wrap_r;

  logic [WIDTH-1:0] q_w;
  logic [WIDTH-1:0] run_t;
  logic [WIDTH-1:0] cell_d;
  logic [WIDTH-1:0] cell_t;
  logic [WIDTH-1:0] cell_j;
  logic [WIDTH-1:0] cell_k;
  cell_mode_e       cell_mode;
  logic             accept;
  logic             run_step;

  assign accept   = bus.cmd_valid && cmd_ready_r;
  assign run_step = (state == RUN) && !bus.cmd_abort && (remaining != '0);

  // Ripple-carry toggle enables: cell i flips when every lower cell is 1.
  assign run_t[0] = 1'b1;
  for (genvar i = 1; i < WIDTH; i++) begin : g_carry
    assign run_t[i] = &q_w[i-1:0];
  end

  // NOTE: every output of this block gets a default first, so no path
  // through the case statements can leave a latch behind.
  always_comb begin
    cell_mode = MODE_HOLD;
    cell_d    = '0;
    cell_t    = '0;
    cell_j    = '0;
    cell_k    = '0;
    if (state == EXEC) begin
      unique case (op_r)
        OP_LOAD:   begin cell_mode = MODE_D;  cell_d = arg_r; end
        OP_TOGGLE: begin cell_mode = MODE_T;  cell_t = arg_r; end
        OP_JK:     begin cell_mode = MODE_JK; cell_j = arg_r; cell_k = arg2_r; end
        OP_CLEAR:  begin cell_mode = MODE_D;  cell_d = '0;    end
        OP_PRESET: begin cell_mode = MODE_D;  cell_d = INIT;  end
        default:   cell_mode = MODE_HOLD;
      endcase
    end else if (run_step) begin
      cell_mode = MODE_T;
      cell_t    = run_t;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    ff_cell #(
      .INIT_BIT (INIT[i])
    ) u_cell (
      .clock  (clock),
      .preset (preset),
      .mode   (cell_mode),
      .d      (cell_d[i]),
      .t      (cell_t[i]),
      .j      (cell_j[i]),
      .k      (cell_k[i]),
      .q      (q_w[i])
    );
  end

  always_ff @(posedge clock or negedge preset) begin
    if (!preset) begin
      state       <= IDLE;
      op_r        <= OP_NOP;
      arg_r       <= '0;
      arg2_r      <= '0;
      remaining   <= '0;
      cmd_ready_r <= 1'b1;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      wrap_r      <= 1'b0;
    end else begin
      done_r <= 1'b0;
      wrap_r <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            op_r        <= bus.cmd_op;
            arg_r       <= bus.cmd_arg;
            arg2_r      <= bus.cmd_arg2;
            busy_r      <= 1'b1;
            cmd_ready_r <= 1'b0;
            if (bus.cmd_op == OP_RUN) begin
              state     <= RUN;
              remaining <= bus.cmd_arg;
            end else begin
              state     <= EXEC;
            end
          end
        end
        EXEC: begin
          state       <= IDLE;
          done_r      <= 1'b1;
          busy_r      <= 1'b0;
          cmd_ready_r <= 1'b1;
        end
        RUN: begin
          if (bus.cmd_abort) begin
            state       <= IDLE;
            remaining   <= '0;
            busy_r      <= 1'b0;
            cmd_ready_r <= 1'b1;
          end else if (remaining == '0) begin
            state       <= IDLE;
            done_r      <= 1'b1;
            busy_r      <= 1'b0;
            cmd_ready_r <= 1'b1;
          end else begin
            remaining <= remaining - ONE;
            wrap_r    <= &q_w;
          end
        end
        default: begin
          state       <= IDLE;
          busy_r      <= 1'b0;
          cmd_ready_r <= 1'b1;
        end
      endcase
    end
  end

  assign bus.q         = q_w;
  assign bus.cmd_ready = cmd_ready_r;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.wrap      = wrap_r;

endmodule
